// File: rtl/counter_sched_if.sv
// Request/grant and shared-counter bundle between the requesters and counter_sched.
interface counter_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned SIZE = 8
);
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] len;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_id;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic                 cnt_en;
  logic [SIZE-1:0]      count;

  modport master (
    output req, len,
    input  gnt, gnt_id, done, busy, cnt_en, count
  );

  modport slave (
    input  req, len,
    output gnt, gnt_id, done, busy, cnt_en, count
  );
endinterface

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one up-counter among NREQ requesters;
// each winner gets a counting window of its requested length, then a done pulse.
module counter_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  counter_sched_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            cnt_en_q, cnt_en_d;
  logic [SIZE-1:0] count_q, count_d;
  logic [SIZE-1:0] target_q, target_d;

  logic [IDW-1:0]  winner_c;
  logic            found_c;
  int unsigned     idx;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    winner_c = '0;
    found_c  = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_q) + k) % NREQ;
      if (!found_c && bus.req[IDW'(idx)]) begin
        found_c  = 1'b1;
        winner_c = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_id_d = gnt_id_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    count_d  = count_q;
    target_d = target_q;

    case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          state_d  = ST_GRANT;
          gnt_id_d = winner_c;
          gnt_d    = NREQ'(1) << winner_c;
          target_d = bus.len[32'(winner_c)*SIZE +: SIZE];
        end
      end
      ST_GRANT: begin
        if (!bus.req[gnt_id_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          last_d  = gnt_id_q;
        end else begin
          count_d = '0;
          if (target_q == '0) begin
            state_d = ST_DONE;
            done_d  = gnt_q;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // An abort freezes the counter at its current value.
        if (!bus.req[gnt_id_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          last_d  = gnt_id_q;
        end else begin
          count_d = count_q + SIZE'(1);
          if (count_q == target_q - SIZE'(1)) begin
            state_d = ST_DONE;
            done_d  = gnt_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        last_d  = gnt_id_q;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d   = (state_d != ST_IDLE);
    cnt_en_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      last_q   <= IDW'(NREQ - 1);
      gnt_id_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      cnt_en_q <= 1'b0;
      count_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_id_q <= gnt_id_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      cnt_en_q <= cnt_en_d;
      count_q  <= count_d;
      target_q <= target_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.cnt_en = cnt_en_q;
  assign bus.count  = count_q;

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Round-robin scheduler that shares one SIZE-bit up-counter among NREQ requesters. Each requester asks for a counting window of len cycles.
- The block arbitrates, clears the counter, drives its enable for exactly len cycles, then pulses done back to the winner.
- It sits between security/timing FSMs (timeouts, lockout delays) and a single shared counter resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the grant index; must equal ceil(log2(NREQ)).
- SIZE, 8, counter and window-length width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- req  input  NREQ  per-requester request level; held until done is seen or the requester aborts.
- len  input  NREQ*SIZE  packed window lengths; requester i uses len[i*SIZE +: SIZE]. Sampled only in the cycle the grant is issued.
- gnt  output  NREQ  one-hot grant; high from GRANT through DONE.
- gnt_id  output  IDW  index of the current/last winner.
- done  output  NREQ  one-cycle completion pulse to the winner.
- busy  output  1  high in any state other than IDLE.
- cnt_en  output  1  counter enable; high only in RUN.
- count  output  SIZE  shared counter value.

Behaviour:
- Reset (rst=0 at an edge) has priority over everything:
  - state=IDLE; gnt, done, busy, cnt_en = 0; count=0; gnt_id=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- States are IDLE, GRANT, RUN, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching from last+1 upward with wrap.
  - Next state GRANT; gnt_id=winner; gnt=onehot(winner).
  - With no request, remain in IDLE and hold count.
- GRANT (1 cycle):
  - Latch target=len[winner]; clear count to 0.
  - If the latched len==0, next state is DONE (zero-length window, counter never enabled). Otherwise next state is RUN.
- RUN:
  - cnt_en=1; count increments by 1 every cycle.
  - At the edge where count==target-1 is incremented, next state is DONE, so count==target on entering DONE.
- DONE (1 cycle):
  - done[winner]=1; gnt still asserted; last=winner; next state IDLE.
  - gnt drops on entering IDLE.
- Abort:
  - If req[winner] is 0 in GRANT or RUN, the next state is IDLE.
  - No done pulse; count holds its current value; last=winner.
- Latency:
  - req rising in IDLE at cycle 0 gives gnt at cycle 1 and RUN at cycles 2..len+1.
  - done pulses at cycle len+2; back in IDLE at len+3.
  - len=0 gives done at cycle 2.
- Arithmetic:
  - count never wraps inside a window; the maximum window is 2^SIZE-1 cycles.
  - count holds its final value in DONE and IDLE until the next GRANT clears it.
- Simultaneous events:
  - Requests arriving during busy wait; they are evaluated only in IDLE.
  - A requester still holding req after its done re-enters arbitration in IDLE, behind any other pending requester (round-robin).
- Reset mid-operation: any state returns to IDLE within the same edge; no done pulse.
- Changes to len after the grant are ignored for that window.

Test Plan:
- Reset then req=0001, len0=3 -> gnt=0001 at cycle 1; cnt_en high cycles 2-4; count=3; done=0001 pulse at cycle 5; busy low at cycle 6.
- req=1111 held continuously, all len=1 -> grants in order 0,1,2,3,0; each window is 4 cycles (GRANT, RUN, DONE, IDLE).
- req=0100, len2=0 -> GRANT then DONE immediately; cnt_en never high; count=0; done=0100.
- req=0010, len1=10; drop req1 after 4 RUN cycles -> return to IDLE; no done; count holds 4.
- rst=0 asserted mid-RUN (count=5) -> next edge: state IDLE, count=0, gnt=0, done=0; after release, requester 0 wins first.
- SIZE=8, len=255 -> count reaches 255 with no wrap; done at cycle 257.
